// File: rtl/conc_stim_player.sv
// Vector replay engine: loads OPW-bit stimulus vectors into a small memory and
// replays them one entry per step, with per-entry hold, one-shot or loop mode.
module conc_stim_player #(
  parameter int OPW    = 3,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [OPW-1:0]    load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_loop,
  input  logic [ADDR_W:0]   run_len,
  input  logic [3:0]        hold,
  output logic [OPW-1:0]    stim,
  output logic              stim_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state, state_n;
  logic [OPW-1:0]      mem [DEPTH];
  logic [ADDR_W:0]     len, len_n;
  logic [3:0]          hld, hld_n, hcnt, hcnt_n;
  logic [OPW-1:0]      stim_n;
  logic                valid_n, done_n;
  logic [ADDR_W-1:0]   pc_n, pc_inc;
  logic [WRAP_W-1:0]   wrap_n;
  logic                can_start, last_entry;
  logic [ADDR_W:0]     run_clamp;

  assign pc_inc     = pc + 1'b1;
  assign last_entry = ({1'b0, pc} == (len - 1'b1));
  assign can_start  = start && !stop && (run_len != '0);
  assign run_clamp  = (run_len > DEPTH_L) ? DEPTH_L : run_len;
  assign busy       = (state == RUN);

  // Memory is deliberately left out of reset so a bench reload is not needed
  // after an abort; writes are locked out while a run is replaying.
  always_ff @(posedge clock) begin
    if (load_en && (state != RUN) && ({1'b0, load_addr} < DEPTH_L))
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      hld        <= '0;
      hcnt       <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      pc         <= '0;
      done       <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      hld        <= hld_n;
      hcnt       <= hcnt_n;
      stim       <= stim_n;
      stim_valid <= valid_n;
      pc         <= pc_n;
      done       <= done_n;
      wrap_cnt   <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    hld_n   = hld;
    hcnt_n  = hcnt;
    stim_n  = stim;
    valid_n = stim_valid;
    pc_n    = pc;
    done_n  = done;
    wrap_n  = wrap_cnt;

    case (state)
      IDLE, DONE: begin
        if (can_start) begin
          state_n = RUN;
          len_n   = run_clamp;
          hld_n   = hold;
          hcnt_n  = hold;
          stim_n  = mem[0];
          valid_n = 1'b1;
          pc_n    = '0;
          wrap_n  = '0;
          done_n  = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          stim_n  = '0;
          valid_n = 1'b0;
          pc_n    = '0;
        end else if (hcnt != '0) begin
          hcnt_n = hcnt - 1'b1;
        end else if (!last_entry) begin
          pc_n   = pc_inc;
          stim_n = mem[pc_inc];
          hcnt_n = hld;
        end else if (mode_loop) begin
          pc_n   = '0;
          stim_n = mem[0];
          hcnt_n = hld;
          wrap_n = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + 1'b1;
        end else begin
          state_n = DONE;
          stim_n  = '0;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/conc_stim_player.md
Name: conc_stim_player

Overview:
- Synthesizable, parametrised vector replay engine for concolic test stimulus.
- An internal memory is loaded with OPW-bit input vectors, then replayed one vector per step onto the design-under-test input bus.
- Supports configurable run length, per-vector hold time, one-shot or loop mode, and a stop/abort.
- Sits between the bench loader and the DUT inputs. Exposes pc and stim_valid for per-cycle trace logging.

Parameters:
- OPW, 3: width of one stimulus vector in bits (DUT input bits plus observation bit).
- DEPTH, 16: number of vector entries in the internal memory.
- ADDR_W, 4: address width; DEPTH <= 2**ADDR_W.
- WRAP_W, 8: width of the loop-wrap counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load_en  in  1  write strobe into vector memory
- load_addr  in  ADDR_W  write address
- load_data  in  OPW  write data
- start  in  1  begin playback (level, sampled each edge)
- stop  in  1  abort playback
- mode_loop  in  1  1 = wrap to entry 0 after the last entry; 0 = one-shot
- run_len  in  ADDR_W+1  number of entries to play; sampled at start
- hold  in  4  each entry is presented for hold+1 cycles; sampled at start
- stim  out  OPW  current stimulus vector
- stim_valid  out  1  stim carries a played vector this cycle
- pc  out  ADDR_W  index of the entry currently on stim
- busy  out  1  state is RUN
- done  out  1  one-shot run completed; held until the next start or reset
- wrap_cnt  out  WRAP_W  loop wraps completed, saturating

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, state is IDLE, internal latches (len, hold, hold counter) are 0. Memory contents are not cleared.
- States: IDLE, RUN, DONE.
- Memory writes:
  - Accepted only in IDLE or DONE: mem[load_addr] <= load_data on the edge.
  - Ignored in RUN.
  - load_addr >= DEPTH is ignored.
- IDLE/DONE -> RUN, on an edge with start=1, stop=0 and run_len != 0:
  - Latch len = min(run_len, DEPTH) and hld = hold.
  - stim <= mem[0], stim_valid <= 1, pc <= 0, hold counter <= hld, wrap_cnt <= 0, done <= 0.
  - Latency: stim is valid the cycle after the start edge.
- start with run_len = 0: ignored; state, done and outputs are unchanged.
- start and stop both high in IDLE/DONE: stop wins, no action.
- RUN, each edge:
  - stop=1: go to IDLE; stim <= 0, stim_valid <= 0, pc <= 0, done stays 0, wrap_cnt is kept.
  - Else, if hold counter != 0: decrement it; stim and pc are unchanged.
  - Else, if pc != len-1: pc <= pc+1, stim <= mem[pc+1], hold counter <= hld.
  - Else (last entry, hold expired), mode_loop=1: pc <= 0, stim <= mem[0], hold counter <= hld, wrap_cnt <= wrap_cnt+1, saturating at all-ones.
  - Else (last entry, hold expired), mode_loop=0: go to DONE; stim <= 0, stim_valid <= 0, done <= 1, pc is kept.
- mode_loop is sampled live, so clearing it mid-run ends playback at the next last-entry boundary.
- start while in RUN is ignored.
- busy = (state == RUN), combinational from the state register.
- Total one-shot run: len*(hold+1) cycles of stim_valid=1.
- Memory read is synchronous into the stim register. No combinational path from inputs to stim.
- Reset asserted mid-RUN: outputs clear immediately; no done pulse.

Test Plan:
- Load mem[0..3] = 101, 010, 111, 001; start with run_len=4, hold=0, mode_loop=0 -> stim 101, 010, 111, 001 on 4 consecutive cycles with stim_valid=1. Next cycle stim=000, stim_valid=0, done=1, pc=3.
- Same data, hold=2 -> each vector held 3 cycles; 12 valid cycles in total; pc steps 0, 1, 2, 3 every third cycle.
- mode_loop=1, run_len=2 -> stim 101, 010, 101, 010, ...; wrap_cnt increments on each return to pc=0. With WRAP_W=2, wrap_cnt saturates at 3.
- stop asserted at the 3rd valid cycle -> next cycle state IDLE, stim=0, stim_valid=0, done=0. A subsequent start replays from mem[0].
- load_en during RUN writing mem[1]=000 -> the write is dropped; a replay after done still shows 010 at pc=1. run_len=0 with start -> no activity. run_len=20 -> clamps to 16 entries.
- Reset pulsed mid-RUN, asynchronous to the clock -> all outputs 0 before the next edge. Memory is retained, and a restart replays the original vectors.
